// File: rtl/gearbox_pair_arbiter.sv
// Two narrow requesters share one 1-to-2 gearbox; each wide word carries both
// halves from a single requester, with round-robin arbitration per pair.
module gearbox_pair_arbiter #(
  parameter int width   = 8,
  parameter int timeout = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up0_vld,
  output logic               up0_rdy,
  input  logic [width-1:0]   up0_data,
  input  logic               up1_vld,
  output logic               up1_rdy,
  input  logic [width-1:0]   up1_data,
  output logic               down_vld,
  input  logic               down_rdy,
  output logic [2*width-1:0] down_data,
  output logic               down_id,
  output logic               down_odd
);

  localparam int CW = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(timeout);

  typedef enum logic {IDLE, HALF} state_t;

  state_t             r_state;
  logic               r_prio;
  logic               r_own;
  logic [width-1:0]   r_half_buf;
  logic [CW-1:0]      r_cnt;
  logic               r_down_vld;
  logic [2*width-1:0] r_down_data;
  logic               r_down_id;
  logic               r_down_odd;

  logic             w_out_free;
  logic             w_any_vld;
  logic             w_gnt;
  logic [width-1:0] w_first_data;
  logic             w_own_vld;
  logic [width-1:0] w_own_data;
  logic             w_first_hs;
  logic             w_pair_hs;
  logic             w_flush;

  // The first beat only fills half_buf, so its grant ignores the output
  // register; the second beat and the flush both need a free output slot.
  always_comb begin
    w_out_free   = !r_down_vld || down_rdy;
    w_any_vld    = up0_vld || up1_vld;
    w_gnt        = (up0_vld && up1_vld) ? r_prio : up1_vld;
    w_first_data = w_gnt ? up1_data : up0_data;
    w_own_vld    = r_own ? up1_vld : up0_vld;
    w_own_data   = r_own ? up1_data : up0_data;
    w_first_hs   = (r_state == IDLE) && w_any_vld;
    w_pair_hs    = (r_state == HALF) && w_own_vld && w_out_free;
    w_flush      = (r_state == HALF) && (timeout != 0) && (r_cnt == TMAX) &&
                   w_out_free && !w_pair_hs;
    if (r_state == IDLE) begin
      up0_rdy = rst_n && w_any_vld && !w_gnt;
      up1_rdy = rst_n && w_any_vld && w_gnt;
    end else begin
      up0_rdy = rst_n && !r_own && w_out_free;
      up1_rdy = rst_n && r_own && w_out_free;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_own       <= 1'b0;
      r_half_buf  <= '0;
      r_cnt       <= '0;
      r_down_vld  <= 1'b0;
      r_down_data <= '0;
      r_down_id   <= 1'b0;
      r_down_odd  <= 1'b0;
    end else begin
      // A reload in the same cycle as a consumer handshake keeps vld high.
      if (w_pair_hs || w_flush) begin
        r_down_vld  <= 1'b1;
        r_down_data <= w_pair_hs ? {r_half_buf, w_own_data} : {r_half_buf, {width{1'b0}}};
        r_down_id   <= r_own;
        r_down_odd  <= w_flush;
      end else if (down_rdy) begin
        r_down_vld  <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_first_hs) begin
            r_half_buf <= w_first_data;
            r_own      <= w_gnt;
            r_cnt      <= '0;
            r_state    <= HALF;
          end
        end
        HALF: begin
          if (w_pair_hs || w_flush) begin
            r_prio  <= ~r_own;
            r_state <= IDLE;
          end else if (r_cnt != TMAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign down_vld  = r_down_vld;
  assign down_data = r_down_data;
  assign down_id   = r_down_id;
  assign down_odd  = r_down_odd;

endmodule
